gearbox_narrow_wide: RTL and testbench
======================================

Name: gearbox_narrow_wide

Overview:
- Parametrised successor to the fixed 8b→32b converter. Packs IN_W-bit beats into RATIO-lane words (IN_W*RATIO bits) in a single clock domain.
- Adds ready/valid backpressure on both sides, selectable lane order, and flush of partial words with a per-lane keep mask.
- Sits between the byte-level source and the wide datapath.

Parameters:
IN_W, 8, width of one input beat (lane), ≥1
RATIO, 4, lanes per output word, ≥2
MSB_FIRST, 1, 1: first beat lands in most-significant lane; 0: least-significant lane
FLUSH_EN, 1, 1: a gap in valid_in flushes a partial word; 0: partial words are retained

Ports:
clk  in  1  single clock, rising edge
reset_L  in  1  asynchronous, active-low reset
data_in  in  IN_W  input beat
valid_in  in  1  data_in valid
ready_in  out  1  block can accept a beat this cycle
data_out  out  IN_W*RATIO  packed word
keep_out  out  RATIO  lane-filled mask for data_out
valid_out  out  1  data_out/keep_out valid
ready_out  in  1  downstream accepts the word

Behaviour:
- Reset (reset_L=0, async): data_out=0, keep_out=0, valid_out=0, lane counter cnt=0, accumulator=0, accumulator keep=0. ready_in is combinational and reads 1 while in reset.
- Beat accept: valid_in && ready_in at a rising edge. Lane k = cnt at accept time; cnt increments.
- Lane placement:
  - MSB_FIRST=1: beat k goes to bits [(RATIO-k)*IN_W-1 -: IN_W], keep bit RATIO-1-k.
  - MSB_FIRST=0: beat k goes to bits [k*IN_W +: IN_W], keep bit k.
  - Unfilled lanes are 0.
- Output register is a 1-entry buffer.
  - out_free = !valid_out || ready_out.
  - Transfer: valid_out && ready_out.
- Complete word:
  - Accepting lane RATIO-1 loads the output register on the same edge (accumulated lanes plus this beat, keep all 1s).
  - cnt→0 and accumulator clears.
  - Latency: valid_out rises one cycle after the last beat is accepted.
- ready_in = !(cnt==RATIO-1 && !out_free). Beats for lanes 0..RATIO-2 are always accepted, even while the output is stalled.
- Flush (FLUSH_EN=1):
  - Condition: valid_in==0 && cnt!=0 && out_free at an edge.
  - Action: output register loads the partial word with its keep mask; cnt→0; accumulator clears.
  - If !out_free, the flush waits. If valid_in returns first, filling continues with no flush.
  - FLUSH_EN=0: the partial word is held indefinitely.
- Hold: while valid_out && !ready_out, data_out and keep_out are stable.
- Transfer with no new load: valid_out→0 next cycle. data_out and keep_out keep their last values; their values are don't-care to consumers.
- Simultaneous transfer and load on the same edge: the new word replaces the old one; valid_out stays 1 (no bubble).
- Sustained valid_in with ready_out=1 gives one word per RATIO cycles; ready_in stays 1.
- Reset mid-operation: any partial or held word is discarded; no output after release until a new word completes.
- cnt width: clog2(RATIO). Wrap occurs only via completion or flush.

Test Plan:
1. Reset; valid_in=1, data_in=FF for 4 cycles, ready_out=1 -> valid_out pulses 1 cycle, one cycle after the 4th accept; data_out=32'hFFFFFFFF, keep_out=4'hF.
2. Back-to-back DD×4 then 00,00,00,03 with no gaps -> words 32'hDDDDDDDD then 32'h00000003, consecutive valid_out pulses 4 cycles apart, ready_in never 0.
3. ready_out=0, stream 8 beats 01..08 -> word 32'h01020304 held stable; ready_in=0 while the 8th beat is offered; raise ready_out -> 32'h01020304 then 32'h05060708 in order, no loss or duplication.
4. FLUSH_EN=1: AA,BB then valid_in=0 -> data_out=32'hAABB0000, keep_out=4'hC. FLUSH_EN=0 with the same stimulus, then CC,DD -> single word 32'hAABBCCDD.
5. MSB_FIRST=0: 11,22,33,44 -> 32'h44332211. IN_W=4, RATIO=8 with nibbles 1..8 -> 32'h87654321.
6. Assert reset_L=0 asynchronously with cnt=2 and a held valid_out -> valid_out/keep_out/data_out=0 immediately; after release, 4 beats 5A -> exactly one word 32'h5A5A5A5A.

Source files
------------

// File: rtl/gearbox_narrow_wide.sv
// Narrow-to-wide gearbox: packs IN_W-bit beats into RATIO-lane words with
// ready/valid on both sides, selectable lane order and optional partial-word flush.
module gearbox_narrow_wide #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1,
  parameter int FLUSH_EN  = 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [IN_W-1:0]       data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [IN_W*RATIO-1:0] data_out,
  output logic [RATIO-1:0]      keep_out,
  output logic                  valid_out,
  input  logic                  ready_out
);

  localparam int W  = IN_W * RATIO;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [RATIO-1:0] acc_keep_q, acc_keep_d;
  logic [W-1:0]     data_out_q, data_out_d;
  logic [RATIO-1:0] keep_out_q, keep_out_d;
  logic             valid_out_q, valid_out_d;

  logic [W-1:0]     merged;
  logic [RATIO-1:0] merged_keep;
  logic [RATIO-1:0] lane_hit;
  logic             out_free;
  logic             at_last;
  logic             accept;
  logic             complete;
  logic             flush;

  // Each lane knows which beat index lands in it; the accumulator plus the
  // incoming beat form the merged word without any variable shifter.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      localparam int BEAT_IDX = (MSB_FIRST != 0) ? (RATIO - 1 - gi) : gi;
      assign lane_hit[gi] = accept && (cnt_q == CW'(BEAT_IDX));
      assign merged[gi*IN_W +: IN_W] = lane_hit[gi] ? data_in : acc_q[gi*IN_W +: IN_W];
      assign merged_keep[gi] = lane_hit[gi] | acc_keep_q[gi];
    end
  endgenerate

  always_comb begin
    out_free = !valid_out_q || ready_out;
    at_last  = (cnt_q == CNT_LAST);
    ready_in = !(at_last && !out_free);
    accept   = valid_in && ready_in;
    complete = accept && at_last;
    flush    = (FLUSH_EN != 0) && !valid_in && (cnt_q != '0) && out_free;
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_keep_d  = acc_keep_q;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    valid_out_d = valid_out_q && !ready_out;
    // A load on the same edge as a transfer simply overwrites: no bubble.
    if (complete || flush) begin
      data_out_d  = complete ? merged : acc_q;
      keep_out_d  = complete ? {RATIO{1'b1}} : acc_keep_q;
      valid_out_d = 1'b1;
      cnt_d       = '0;
      acc_d       = '0;
      acc_keep_d  = '0;
    end else if (accept) begin
      acc_d      = merged;
      acc_keep_d = merged_keep;
      cnt_d      = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      acc_keep_q  <= '0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      acc_keep_q  <= acc_keep_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_gearbox_narrow_wide.sv
// Bench for gearbox_narrow_wide: four configurations driven by one shared stream,
// each checked every cycle against a beat-list reference model plus directed cases.
module tb_gearbox_narrow_wide;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [7:0] din;
  logic       vin;
  logic       rout;

  logic [31:0] d0, d1, d2, d3;
  logic [3:0]  k0, k1, k2;
  logic [7:0]  k3;
  logic        r0, r1, r2, r3;
  logic        v0, v1, v2, v3;

  int checks   = 0;
  int failures = 0;

  // Configurations: {IN_W, RATIO, MSB_FIRST, FLUSH_EN}
  int cfg_w[4]   = '{8, 8, 8, 4};
  int cfg_r[4]   = '{4, 4, 4, 8};
  int cfg_msb[4] = '{1, 1, 0, 0};
  int cfg_fl[4]  = '{1, 0, 1, 1};

  // Reference model: list of accepted beats of the pending word and the output buffer
  logic [7:0]  m_beat[4][8];
  int          m_n[4];
  logic        m_vo[4];
  logic [31:0] m_word[4];
  logic [7:0]  m_keep[4];

  always #5 clk = ~clk;

  gearbox_narrow_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(1), .FLUSH_EN(1)) u0 (
    .clk(clk), .reset_L(reset_L), .data_in(din), .valid_in(vin), .ready_in(r0),
    .data_out(d0), .keep_out(k0), .valid_out(v0), .ready_out(rout));
  gearbox_narrow_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(1), .FLUSH_EN(0)) u1 (
    .clk(clk), .reset_L(reset_L), .data_in(din), .valid_in(vin), .ready_in(r1),
    .data_out(d1), .keep_out(k1), .valid_out(v1), .ready_out(rout));
  gearbox_narrow_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(0), .FLUSH_EN(1)) u2 (
    .clk(clk), .reset_L(reset_L), .data_in(din), .valid_in(vin), .ready_in(r2),
    .data_out(d2), .keep_out(k2), .valid_out(v2), .ready_out(rout));
  gearbox_narrow_wide #(.IN_W(4), .RATIO(8), .MSB_FIRST(0), .FLUSH_EN(1)) u3 (
    .clk(clk), .reset_L(reset_L), .data_in(din[3:0]), .valid_in(vin), .ready_in(r3),
    .data_out(d3), .keep_out(k3), .valid_out(v3), .ready_out(rout));

  function automatic logic [31:0] get_d(int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic [31:0] get_k(int i);
    case (i)
      0: return {28'h0, k0};
      1: return {28'h0, k1};
      2: return {28'h0, k2};
      default: return {24'h0, k3};
    endcase
  endfunction

  function automatic logic get_v(int i);
    case (i)
      0: return v0;
      1: return v1;
      2: return v2;
      default: return v3;
    endcase
  endfunction

  function automatic logic get_r(int i);
    case (i)
      0: return r0;
      1: return r1;
      2: return r2;
      default: return r3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_free(int i);
    return !m_vo[i] || rout;
  endfunction

  function automatic logic model_ready(int i);
    return !((m_n[i] == cfg_r[i] - 1) && !model_free(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_n[i]    = 0;
      m_vo[i]   = 1'b0;
      m_word[i] = 32'h0;
      m_keep[i] = 8'h0;
    end
  endtask

  // Build the output word from the list of beats: beat k goes to lane k or RATIO-1-k
  task automatic model_emit(int i);
    logic [31:0] w;
    logic [7:0]  k;
    int          lane;
    w = 32'h0;
    k = 8'h0;
    for (int b = 0; b < m_n[i]; b++) begin
      lane = (cfg_msb[i] != 0) ? (cfg_r[i] - 1 - b) : b;
      w = w | ({24'h0, m_beat[i][b]} << (cfg_w[i] * lane));
      k = k | (8'h1 << lane);
    end
    m_word[i] = w;
    m_keep[i] = k;
    m_vo[i]   = 1'b1;
    m_n[i]    = 0;
  endtask

  task automatic model_edge();
    logic free;
    logic acc;
    logic [7:0] mask;
    for (int i = 0; i < 4; i++) begin
      free = model_free(i);
      acc  = vin && model_ready(i);
      mask = 8'hFF >> (8 - cfg_w[i]);
      if (m_vo[i] && rout) m_vo[i] = 1'b0;
      if (acc) begin
        m_beat[i][m_n[i]] = din & mask;
        m_n[i] = m_n[i] + 1;
        if (m_n[i] == cfg_r[i]) model_emit(i);
      end else if ((cfg_fl[i] != 0) && !vin && (m_n[i] != 0) && free) begin
        model_emit(i);
      end
    end
  endtask

  // One clock: inputs already driven; check ready, clock, update model, check outputs
  task automatic step();
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("u%0d.ready_in", i), {31'h0, get_r(i)}, {31'h0, model_ready(i)});
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d.valid_out", i), {31'h0, get_v(i)}, {31'h0, m_vo[i]});
      if (m_vo[i]) begin
        chk($sformatf("u%0d.data_out", i), get_d(i), m_word[i]);
        chk($sformatf("u%0d.keep_out", i), get_k(i), {24'h0, m_keep[i]});
      end
    end
  endtask

  task automatic beat(input logic [7:0] d);
    vin = 1'b1;
    din = d;
    step();
  endtask

  task automatic idle();
    vin = 1'b0;
    step();
  endtask

  task automatic do_reset();
    vin     = 1'b0;
    din     = 8'h0;
    reset_L = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d.rst_valid", i), {31'h0, get_v(i)}, 32'h0);
      chk($sformatf("u%0d.rst_data", i), get_d(i), 32'h0);
      chk($sformatf("u%0d.rst_keep", i), get_k(i), 32'h0);
      chk($sformatf("u%0d.rst_ready", i), {31'h0, get_r(i)}, 32'h1);
    end
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0;
    vin     = 1'b0;
    din     = 8'h0;
    rout    = 1'b1;

    // Full word of FF, single valid_out pulse
    do_reset();
    rout = 1'b1;
    for (int b = 0; b < 4; b++) begin
      beat(8'hFF);
      chk("t1.valid", {31'h0, v0}, (b == 3) ? 32'h1 : 32'h0);
    end
    chk("t1.data", d0, 32'hFFFFFFFF);
    chk("t1.keep", {28'h0, k0}, 32'hF);
    idle();
    chk("t1.valid_drop", {31'h0, v0}, 32'h0);

    // Back-to-back words, no gaps
    do_reset();
    rout = 1'b1;
    begin
      logic [7:0] seq [8];
      seq = '{8'hDD, 8'hDD, 8'hDD, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h03};
      for (int b = 0; b < 8; b++) begin
        vin = 1'b1;
        din = seq[b];
        #1;
        chk("t2.ready", {31'h0, r0}, 32'h1);
        beat(seq[b]);
        chk("t2.valid", {31'h0, v0}, (b == 3 || b == 7) ? 32'h1 : 32'h0);
        if (b == 3) chk("t2.word0", d0, 32'hDDDDDDDD);
        if (b == 7) chk("t2.word1", d0, 32'h00000003);
      end
    end

    // Downstream stall: first word held, 8th beat refused until ready_out rises
    do_reset();
    rout = 1'b0;
    for (int b = 1; b <= 7; b++) beat(8'(b));
    chk("t3.hold_valid", {31'h0, v0}, 32'h1);
    chk("t3.hold_data", d0, 32'h01020304);
    vin = 1'b1;
    din = 8'h08;
    #1;
    chk("t3.stall_ready", {31'h0, r0}, 32'h0);
    repeat (2) begin
      beat(8'h08);
      chk("t3.held_data", d0, 32'h01020304);
    end
    rout = 1'b1;
    beat(8'h08);
    chk("t3.second_valid", {31'h0, v0}, 32'h1);
    chk("t3.second_data", d0, 32'h05060708);
    idle();
    chk("t3.drained", {31'h0, v0}, 32'h0);

    // Flush of a partial word vs retention when flush is disabled
    do_reset();
    rout = 1'b1;
    beat(8'hAA);
    beat(8'hBB);
    idle();
    chk("t4.flush_valid", {31'h0, v0}, 32'h1);
    chk("t4.flush_data", d0, 32'hAABB0000);
    chk("t4.flush_keep", {28'h0, k0}, 32'hC);
    for (int g = 0; g < 3; g++) begin
      idle();
      chk("t4.noflush_valid", {31'h0, v1}, 32'h0);
    end
    beat(8'hCC);
    beat(8'hDD);
    chk("t4.retained_valid", {31'h0, v1}, 32'h1);
    chk("t4.retained_data", d1, 32'hAABBCCDD);
    chk("t4.retained_keep", {28'h0, k1}, 32'hF);
    idle();
    idle();

    // LSB-first ordering and the 4-bit x 8-lane variant
    do_reset();
    rout = 1'b1;
    beat(8'h11);
    beat(8'h22);
    beat(8'h33);
    beat(8'h44);
    chk("t5.lsb_data", d2, 32'h44332211);
    do_reset();
    for (int b = 1; b <= 8; b++) beat(8'(b));
    chk("t5.nib_valid", {31'h0, v3}, 32'h1);
    chk("t5.nib_data", d3, 32'h87654321);
    chk("t5.nib_keep", {24'h0, k3}, 32'hFF);
    idle();

    // Asynchronous reset with a held word and a partial word in flight
    do_reset();
    rout = 1'b0;
    for (int b = 1; b <= 6; b++) beat(8'(b));
    chk("t6.pre_valid", {31'h0, v0}, 32'h1);
    vin = 1'b0;
    #3;
    reset_L = 1'b0;
    model_reset();
    #1;
    chk("t6.async_valid", {31'h0, v0}, 32'h0);
    chk("t6.async_data", d0, 32'h0);
    chk("t6.async_keep", {28'h0, k0}, 32'h0);
    chk("t6.async_ready", {31'h0, r0}, 32'h1);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    rout = 1'b1;
    for (int b = 0; b < 4; b++) begin
      beat(8'h5A);
      chk("t6.valid", {31'h0, v0}, (b == 3) ? 32'h1 : 32'h0);
    end
    chk("t6.data", d0, 32'h5A5A5A5A);
    idle();
    chk("t6.single", {31'h0, v0}, 32'h0);
    idle();
    chk("t6.single2", {31'h0, v0}, 32'h0);

    // Randomized traffic checked every cycle by the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      vin  = ($urandom_range(0, 9) < 7);
      din  = 8'($urandom);
      rout = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
